delay_hs_r1: RTL

DELAY_HS_R1 -- requirements
Module: delay_hs_r1

---
 rtl/delay_hs_r1_pkg.sv | 29 ++
 rtl/delay_hs_r1_if.sv | 30 +++
 rtl/delay_hs_r1_stage.sv | 56 +++++
 rtl/delay_hs_r1.sv | 112 +++++++++++
 4 files changed

// File: rtl/delay_hs_r1_pkg.sv
// Shared definitions for the delay_hs_r1 elastic delay line.
// Latency: none (types, helpers and lane packing macros only).
// Backpressure: not applicable.
`ifndef DELAY_HS_R1_PKG_SV
`define DELAY_HS_R1_PKG_SV

// Lane i of a packed multi-lane vector; usable on either side of an assignment.
`define DHS_LANE(vec, i, bw) vec[(bw)*(i) +: (bw)]

package delay_hs_r1_pkg;

  // Total packed vector width for DEPTH lanes of BIT_WIDTH bits.
  function automatic int bus_width(input int bit_width, input int depth);
    return bit_width * depth;
  endfunction

  // Bit offset of lane i inside the packed vector.
  function automatic int lane_lsb(input int lane, input int bit_width);
    return lane * bit_width;
  endfunction

  // Width of the occupancy counter; never collapses to zero bits.
  function automatic int occ_width(input int delay);
    return (delay < 1) ? 1 : $clog2(delay + 1);
  endfunction

endpackage

`endif

// File: rtl/delay_hs_r1_if.sv
// Upstream and downstream valid/ready handshake bundle for delay_hs_r1.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carry the stall in each direction.
interface delay_hs_r1_if
  import delay_hs_r1_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int DEPTH     = 2
);
  localparam int W = bus_width(BIT_WIDTH, DEPTH);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dataIn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dataOut;

  // Side that produces entries and consumes results.
  modport master (
    output in_valid, dataIn, out_ready,
    input  in_ready, out_valid, dataOut
  );

  // The delay line itself.
  modport slave (
    input  in_valid, dataIn, out_ready,
    output in_ready, out_valid, dataOut
  );
endinterface

// File: rtl/delay_hs_r1_stage.sv
// One elastic stage: a valid flag plus DEPTH lanes of data.
// Latency: one cycle from load to vld.
// Backpressure: keeps its entry while dn_rdy is low; loads whenever empty or draining.
module delay_hs_stage
  import delay_hs_r1_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int DEPTH     = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    flush,
  input  logic                                    up_vld,
  input  logic [bus_width(BIT_WIDTH, DEPTH)-1:0] up_dat,
  input  logic                                    dn_rdy,
  output logic                                    vld,
  output logic [bus_width(BIT_WIDTH, DEPTH)-1:0] dat
);
  logic [DEPTH-1:0][BIT_WIDTH-1:0] lane_q;
  logic                            take;

  // The slot can take a new entry when it is empty or its entry moves on this edge.
  assign take = ~vld | dn_rdy;

  // Valid flag: reset and flush clear it, otherwise it follows the upstream valid on a take.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (en && take) begin
      vld <= up_vld;
    end
  end

  // Lane data: cleared only by reset; flush leaves stale contents in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
    end else if (!flush && en && take && up_vld) begin
      for (int l = 0; l < DEPTH; l++) begin
        lane_q[l] <= `DHS_LANE(up_dat, l, BIT_WIDTH);
      end
    end
  end

  // Repack the lanes into the flat vector seen by the next stage.
  always_comb begin
    dat = '0;
    for (int l = 0; l < DEPTH; l++) begin
      `DHS_LANE(dat, l, BIT_WIDTH) = lane_q[l];
    end
  end

endmodule

// File: rtl/delay_hs_r1.sv
// Elastic DELAY-stage delay line with valid/ready, flush, freeze; DELAY_HS_OCC_EN adds an occ port.
// Latency: DELAY cycles unstalled at one entry per cycle; DELAY==0 is a pure wire.
// Backpressure: bubbles collapse behind a stalled output; in_ready drops only when every stage is full.
module delay_hs_r1
  import delay_hs_r1_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int DEPTH     = 2,
  parameter int DELAY     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_n,
  input  logic flush,
  delay_hs_r1_if.slave bus
`ifdef DELAY_HS_OCC_EN
  ,
  output logic [occ_width(DELAY)-1:0] occ
`endif
);
  localparam int W  = bus_width(BIT_WIDTH, DEPTH);
  localparam int OW = occ_width(DELAY);

  if (DELAY == 0) begin : g_wire
    // No storage at all: handshake and data pass straight through.
    logic unused_ctl;

    assign bus.dataOut   = bus.dataIn;
    assign bus.out_valid = bus.in_valid;
    assign bus.in_ready  = bus.out_ready;
    assign unused_ctl    = ^{clk, rst, en_n, flush};

`ifdef DELAY_HS_OCC_EN
    assign occ = '0;
`endif

  end else begin : g_pipe
    logic [DELAY-1:0]        vld;
    logic [DELAY-1:0][W-1:0] dat;
    logic [DELAY-1:0]        dn_rdy;
    logic                    tail_full;
    logic                    en;

    assign en = ~en_n;

    // dn_rdy[k]: whatever sits after stage k will make room this edge, i.e. the
    // output drains or some later stage is empty. Computed from the valid flags
    // directly so the ready chain does not ripple through neighbouring bits.
    always_comb begin
      tail_full = 1'b1;
      dn_rdy    = '0;
      for (int k = DELAY - 1; k >= 0; k--) begin
        dn_rdy[k] = bus.out_ready | ~tail_full;
        tail_full = tail_full & vld[k];
      end
    end

    for (genvar k = 0; k < DELAY; k++) begin : g_stage
      logic         up_vld;
      logic [W-1:0] up_dat;

      if (k == 0) begin : g_head
        assign up_vld = bus.in_valid;
        assign up_dat = bus.dataIn;
      end else begin : g_body
        assign up_vld = vld[k-1];
        assign up_dat = dat[k-1];
      end

      delay_hs_stage #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DEPTH)
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .flush  (flush),
        .up_vld (up_vld),
        .up_dat (up_dat),
        .dn_rdy (dn_rdy[k]),
        .vld    (vld[k]),
        .dat    (dat[k])
      );
    end

    // Stage 0 takes the upstream entry exactly when in_ready is high, because the
    // stage's own load is gated by the same rst/flush/en terms.
    assign bus.in_ready  = ~rst & en & ~flush & (~vld[0] | dn_rdy[0]);
    assign bus.out_valid = vld[DELAY-1];
    assign bus.dataOut   = dat[DELAY-1];

`ifdef DELAY_HS_OCC_EN
    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = vld[DELAY-1] & bus.out_ready;

    // Occupancy tracks the number of valid stages: +1 per accept, -1 per release.
    always_ff @(posedge clk) begin
      if (rst) begin
        occ <= '0;
      end else if (flush) begin
        occ <= '0;
      end else if (en) begin
        occ <= occ + OW'(in_xfer) - OW'(out_xfer);
      end
    end
`endif
  end

endmodule
